// File: rtl/dmux_nway_stream.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmux_nway_stream
//
// Purpose:
//   Streaming 1-to-WAYS demultiplexer. Each upstream word is steered to the
//   output channel named by in_sel. Every channel has a one-entry holding
//   register, so the latency from input to output is exactly one cycle. A
//   channel can take a new word in the same cycle it hands one out, which
//   gives one word per cycle per channel.
//
//   While a channel is empty, its out_data reads all-zero.
//
//   A word with an out-of-range in_sel is always accepted and then thrown
//   away. This can only happen when WAYS is not a power of two.
//
// Optional feature:
//   `define DMUX_DROP_COUNT_EN to add the drop_count port. It is a 16-bit
//   saturating count of the words thrown away because their in_sel was out
//   of range.
//
// Parameters:
//   WIDTH  data bits per word (1..32)
//   WAYS   number of output channels (2..16)
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous, active-high
//   in_valid    upstream word present
//   in_ready    word accepted this cycle (combinational from in_sel/out_ready)
//   in_data     upstream word
//   in_sel      destination channel index
//   out_valid   bit i: channel i holds a word
//   out_ready   bit i: channel i consumer takes the word
//   out_data    channel i occupies bits [i*WIDTH +: WIDTH]
//   drop_count  discarded-word counter (DMUX_DROP_COUNT_EN only)
// -----------------------------------------------------------------------------
module dmux_nway_stream #(
    parameter  int WIDTH = 16,
    parameter  int WAYS  = 8,
    localparam int SEL_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      in_sel,
    output logic [WAYS-1:0]       out_valid,
    input  logic [WAYS-1:0]       out_ready,
    output logic [WAYS*WIDTH-1:0] out_data
`ifdef DMUX_DROP_COUNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);

    // Every in_sel code has an entry in these tables. The codes past WAYS are
    // padding entries, so in_sel can index the tables directly without a
    // range compare.
    localparam int NSEL = 1 << SEL_W;

    logic [NSEL-1:0] w_ready_pad;
    logic            w_accept;

    genvar gi;

    // Per-code ready. A padding (illegal) code always reads ready, so the
    // word is swallowed and never stalls upstream.
    generate
        for (gi = 0; gi < NSEL; gi++) begin : g_sel
            if (gi < WAYS) begin : g_real
                assign w_ready_pad[gi] = ~out_valid[gi] | out_ready[gi];
            end else begin : g_pad
                assign w_ready_pad[gi] = 1'b1;
            end
        end
    endgenerate

    assign in_ready = w_ready_pad[in_sel];
    assign w_accept = in_valid & in_ready;

    // Channel holding registers. The decode against gi only matches legal
    // codes, so an out-of-range accept loads nothing.
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_chan
            logic             r_valid;
            logic [WIDTH-1:0] r_data;
            logic             w_load;
            logic             w_pop;

            assign w_load = w_accept & (in_sel == SEL_W'(gi));
            assign w_pop  = r_valid & out_ready[gi];

            // A load takes priority over a pop. On a same-cycle pop and load
            // the channel stays full and holds the new word.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (w_load) begin
                    r_valid <= 1'b1;
                    r_data  <= in_data;
                end else if (w_pop) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end
            end

            assign out_valid[gi]                 = r_valid;
            assign out_data[gi*WIDTH +: WIDTH]   = r_data;
        end
    endgenerate

`ifdef DMUX_DROP_COUNT_EN
    // Legality flag for each code, using the same padding idea as the ready
    // table above.
    logic [NSEL-1:0] w_legal_pad;
    logic            w_drop;
    logic [15:0]     r_drop_count;

    generate
        for (gi = 0; gi < NSEL; gi++) begin : g_legal
            assign w_legal_pad[gi] = (gi < WAYS) ? 1'b1 : 1'b0;
        end
    endgenerate

    assign w_drop = w_accept & ~w_legal_pad[in_sel];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count <= 16'd0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_dmux_nway_stream.sv
`timescale 1ns/1ps
// Testbench for dmux_nway_stream.
//
// It drives two instances:
//   - u_dut8 (WAYS=8) runs the directed scenarios.
//   - u_dut5 (WAYS=5) can see illegal selects. It runs the drop scenarios,
//     a reset in the middle of traffic, and a long random run.
//
// The random run is checked against a model that keeps one queue of
// outstanding words per channel.
module tb_dmux_nway_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- WAYS = 8 instance ----------------
    logic         rst8, v8, rdy8;
    logic [15:0]  d8;
    logic [2:0]   s8;
    logic [7:0]   ov8, or8;
    logic [127:0] od8;

    // ---------------- WAYS = 5 instance ----------------
    logic         rst5, v5, rdy5;
    logic [15:0]  d5;
    logic [2:0]   s5;
    logic [4:0]   ov5, or5;
    logic [79:0]  od5;

`ifdef DMUX_DROP_COUNT_EN
    logic [15:0]  dc8, dc5;
`endif

    dmux_nway_stream #(.WIDTH(16), .WAYS(8)) u_dut8 (
        .clk(clk), .reset(rst8), .in_valid(v8), .in_ready(rdy8),
        .in_data(d8), .in_sel(s8), .out_valid(ov8), .out_ready(or8),
        .out_data(od8)
`ifdef DMUX_DROP_COUNT_EN
        , .drop_count(dc8)
`endif
    );

    dmux_nway_stream #(.WIDTH(16), .WAYS(5)) u_dut5 (
        .clk(clk), .reset(rst5), .in_valid(v5), .in_ready(rdy5),
        .in_data(d5), .in_sel(s5), .out_valid(ov5), .out_ready(or5),
        .out_data(od5)
`ifdef DMUX_DROP_COUNT_EN
        , .drop_count(dc5)
`endif
    );

    // Reference model for the WAYS=5 instance.
    // One queue of outstanding words per channel, plus a saturating drop
    // count.
    logic [15:0] q5 [5][$];
    int          drops5 = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one cycle on the WAYS=5 instance. It is called just after a
    // negedge: it drives the inputs, checks the outputs against the model,
    // advances the model across the next rising edge, and returns at the
    // following negedge.
    task automatic step5(input logic v, input logic [2:0] s, input logic [15:0] d,
                         input logic [4:0] ordy);
        logic exp_rdy;
        v5 = v; s5 = s; d5 = d; or5 = ordy;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ch%0d_valid", i), 128'(ov5[i]), 128'(q5[i].size() != 0));
            chk($sformatf("ch%0d_data", i), 128'(od5[i*16 +: 16]),
                128'((q5[i].size() != 0) ? q5[i][0] : 16'h0000));
        end
        if (s >= 3'd5) exp_rdy = 1'b1;
        else           exp_rdy = (q5[s].size() == 0) || ordy[s];
        chk("in_ready5", 128'(rdy5), 128'(exp_rdy));
`ifdef DMUX_DROP_COUNT_EN
        chk("drop_count5", 128'(dc5), 128'(drops5));
`endif
        for (int i = 0; i < 5; i++)
            if (q5[i].size() != 0 && ordy[i]) void'(q5[i].pop_front());
        if (v && exp_rdy) begin
            if (s < 3'd5) q5[s].push_back(d);
            else if (drops5 < 65535) drops5++;
        end
        @(negedge clk);
    endtask

    task automatic reset5_model();
        for (int i = 0; i < 5; i++) q5[i].delete();
        drops5 = 0;
    endtask

    logic [127:0] e8;

    initial begin
        rst8 = 1'b1; v8 = 1'b0; d8 = '0; s8 = '0; or8 = '0;
        rst5 = 1'b1; v5 = 1'b0; d5 = '0; s5 = '0; or5 = '0;
        @(negedge clk); @(negedge clk);
        rst8 = 1'b0;
        #1;

        // ---------------- WAYS=8 directed ----------------
        chk("reset_out_valid", 128'(ov8), 128'(8'h00));
        chk("reset_out_data", od8, 128'h0);
        chk("reset_in_ready", 128'(rdy8), 128'(1'b1));
`ifdef DMUX_DROP_COUNT_EN
        chk("reset_drop8", 128'(dc8), 128'(16'h0));
`endif

        // Fill all eight channels with no consumer ready.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v8 = 1'b1; s8 = 3'(i); d8 = 16'hA000 + 16'(i); or8 = 8'h00;
            #1;
            chk($sformatf("fill_ready_%0d", i), 128'(rdy8), 128'(1'b1));
        end
        @(negedge clk);
        v8 = 1'b0;
        #1;
        chk("fill_out_valid", 128'(ov8), 128'(8'hFF));
        for (int i = 0; i < 8; i++) begin
            e8[i*16 +: 16] = 16'hA000 + 16'(i);
        end
        chk("fill_out_data", od8, e8);
        for (int i = 0; i < 8; i++) begin
            s8 = 3'(i);
            #1;
            chk($sformatf("full_ready_%0d", i), 128'(rdy8), 128'(1'b0));
        end

        // Channel 3 pops and loads in the same cycle.
        @(negedge clk);
        v8 = 1'b1; s8 = 3'd3; d8 = 16'h1234; or8 = 8'h08;
        #1;
        chk("ch3_swap_ready", 128'(rdy8), 128'(1'b1));
        @(negedge clk);
        v8 = 1'b0; or8 = 8'h00;
        #1;
        e8[3*16 +: 16] = 16'h1234;
        chk("ch3_swap_valid", 128'(ov8), 128'(8'hFF));
        chk("ch3_swap_data", od8, e8);

        // Channel 5 pops with no load.
        @(negedge clk);
        or8 = 8'h20;
        @(negedge clk);
        or8 = 8'h00;
        #1;
        e8[5*16 +: 16] = 16'h0000;
        chk("ch5_pop_valid", 128'(ov8), 128'(8'hDF));
        chk("ch5_pop_data", od8, e8);

        // in_ready is low only while in_sel addresses a full, stalled channel.
        s8 = 3'd2; #1;
        chk("stall_sel_full", 128'(rdy8), 128'(1'b0));
        s8 = 3'd5; #1;
        chk("stall_sel_empty", 128'(rdy8), 128'(1'b1));

        // Full throughput on channel 0: one new word per cycle while popping.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            v8 = 1'b1; s8 = 3'd0; d8 = 16'hB000 + 16'(k); or8 = 8'h01;
            #1;
            chk($sformatf("tput_ready_%0d", k), 128'(rdy8), 128'(1'b1));
            chk($sformatf("tput_data_%0d", k), 128'(od8[15:0]),
                128'((k == 0) ? 16'hA000 : (16'hB000 + 16'(k - 1))));
        end
        @(negedge clk);
        v8 = 1'b0; or8 = 8'h00;
        #1;
        chk("tput_last", 128'(od8[15:0]), 128'(16'hB002));
        chk("tput_valid", 128'(ov8), 128'(8'hDF));

        // A reset in the middle of traffic wins over a same-cycle accept.
        @(negedge clk);
        rst8 = 1'b1; v8 = 1'b1; s8 = 3'd4; d8 = 16'hDEAD;
        @(negedge clk);
        rst8 = 1'b0; v8 = 1'b0;
        #1;
        chk("midreset_valid", 128'(ov8), 128'(8'h00));
        chk("midreset_data", od8, 128'h0);

        // ---------------- WAYS=5 directed + random ----------------
        @(negedge clk);
        rst5 = 1'b0;
        reset5_model();

        // Illegal select: accepted, discarded, and counted.
        for (int k = 0; k < 3; k++) step5(1'b1, 3'd6, 16'hC000 + 16'(k), 5'h00);
        step5(1'b0, 3'd0, 16'h0, 5'h00);
        chk("drop_no_valid", 128'(ov5), 128'(5'h00));
`ifdef DMUX_DROP_COUNT_EN
        chk("drop_count_3", 128'(dc5), 128'(16'd3));
        // Saturation of the drop counter.
        v5 = 1'b1; s5 = 3'd6; or5 = 5'h00;
        for (int k = 0; k < 65540; k++) @(negedge clk);
        drops5 = (drops5 + 65540 > 65535) ? 65535 : drops5 + 65540;
        step5(1'b0, 3'd0, 16'h0, 5'h00);
        chk("drop_count_sat", 128'(dc5), 128'(16'hFFFF));
`endif

        // Fill channels 0-2, then reset together with an accept on sel=4.
        for (int k = 0; k < 3; k++) step5(1'b1, 3'(k), 16'hD000 + 16'(k), 5'h00);
        rst5 = 1'b1; v5 = 1'b1; s5 = 3'd0; d5 = 16'hEEEE; or5 = 5'h00;
        #1;
        chk("reset_ready_comb", 128'(rdy5), 128'(1'b0));
        s5 = 3'd4;
        @(negedge clk);
        rst5 = 1'b0;
        reset5_model();
        step5(1'b0, 3'd0, 16'h0, 5'h00);
        chk("reset5_valid", 128'(ov5), 128'(5'h00));
        chk("reset5_data", 128'(od5), 128'h0);

        // Random traffic, with illegal selects mixed in.
        for (int k = 0; k < 10000; k++) begin
            step5(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  16'($urandom), 5'($urandom_range(0, 31)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
